core_reg_file: RTL and testbench

Integer register file for the LETC core: 31 writable 32-bit registers (x1–x31) plus a hardwired-zero x0, two combinational read ports and one synchronous write port. Its write port is fed directly by the writeback source mux output together with the decoded destination index. A per-register busy scoreboard tracks registers with an in-flight producer, such as outstanding loads or CSR reads, so the decode stage can detect RAW hazards.

---
 rtl/core_reg_file.sv | 80 ++++++++
 tb/tb_core_reg_file.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/core_reg_file.sv
// LETC integer register file: x1-x31 storage, hardwired-zero x0, two combinational
// read ports, one write port and a per-register busy scoreboard. Optional: LETC_REG_FILE_BYPASS_EN.
module core_reg_file #(
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_idx,
  output logic [31:0] rs1_rdata,
  output logic        rs1_busy,
  input  logic [4:0]  rs2_idx,
  output logic [31:0] rs2_rdata,
  output logic        rs2_busy,
  input  logic        rd_wen,
  input  logic [4:0]  rd_idx,
  input  logic [31:0] rd_wdata,
  input  logic        rsv_en,
  input  logic [4:0]  rsv_idx
);

  logic [31:0] regs [1:31];
  logic [31:1] busy;

  // Full 32-entry views so index 0 reads as zero without touching storage.
  logic [31:0] read_view [0:31];
  logic [31:0] busy_view;

  assign read_view[0] = 32'h0;
  assign busy_view    = {busy, 1'b0};

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      assign read_view[gi] = regs[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          regs[gi] <= RESET_VALUE;
        end else if (rd_wen && rd_idx == 5'(gi)) begin
          regs[gi] <= rd_wdata;
        end
      end

      // A reservation on the same edge as the completing write wins.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          busy[gi] <= 1'b0;
        end else if (rsv_en && rsv_idx == 5'(gi)) begin
          busy[gi] <= 1'b1;
        end else if (rd_wen && rd_idx == 5'(gi)) begin
          busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

`ifdef LETC_REG_FILE_BYPASS_EN
  logic byp1, byp2;
  logic rsv_hit1, rsv_hit2;

  always_comb begin
    byp1     = rd_wen && (rd_idx != 5'd0) && (rd_idx == rs1_idx);
    byp2     = rd_wen && (rd_idx != 5'd0) && (rd_idx == rs2_idx);
    rsv_hit1 = rsv_en && (rsv_idx != 5'd0) && (rsv_idx == rs1_idx);
    rsv_hit2 = rsv_en && (rsv_idx != 5'd0) && (rsv_idx == rs2_idx);
    rs1_rdata = byp1 ? rd_wdata : read_view[rs1_idx];
    rs2_rdata = byp2 ? rd_wdata : read_view[rs2_idx];
    // A forwarded value retires the reservation unless it is re-reserved now.
    rs1_busy  = byp1 ? rsv_hit1 : busy_view[rs1_idx];
    rs2_busy  = byp2 ? rsv_hit2 : busy_view[rs2_idx];
  end
`else
  always_comb begin
    rs1_rdata = read_view[rs1_idx];
    rs2_rdata = read_view[rs2_idx];
    rs1_busy  = busy_view[rs1_idx];
    rs2_busy  = busy_view[rs2_idx];
  end
`endif

endmodule

// File: tb/tb_core_reg_file.sv
// Self-checking bench for core_reg_file: directed vector table, hand-written
// corner sequences and a randomized run against an array-based reference model.
module tb_core_reg_file;

  localparam logic [31:0] RV = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx, rsv_idx;
  logic [31:0] rs1_rdata, rs2_rdata, rd_wdata;
  logic        rs1_busy, rs2_busy, rd_wen, rsv_en;

  int n_cmp = 0;
  int n_bad = 0;

  core_reg_file #(.RESET_VALUE(RV)) dut (
    .clk(clk), .rst(rst),
    .rs1_idx(rs1_idx), .rs1_rdata(rs1_rdata), .rs1_busy(rs1_busy),
    .rs2_idx(rs2_idx), .rs2_rdata(rs2_rdata), .rs2_busy(rs2_busy),
    .rd_wen(rd_wen), .rd_idx(rd_idx), .rd_wdata(rd_wdata),
    .rsv_en(rsv_en), .rsv_idx(rsv_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        rsv;
    logic [4:0]  rsvi;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic        eb1;
    logic [31:0] e2;
    logic        eb2;
  } vec_t;

  vec_t vecs [11];

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_busy [32];

  initial begin
    // inputs applied for one edge; outputs checked after the edge with wen/rsv dropped
    vecs[0]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vecs[1]  = '{1, 5'd0,  32'h00001234, 0, 5'd0,  5'd0,  5'd5,  32'h0,        0, 32'hDEADBEEF, 0};
    vecs[2]  = '{0, 5'd0,  32'h0,        1, 5'd10, 5'd10, 5'd0,  RV,           1, 32'h0,        0};
    vecs[3]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd10, 5'd0,  RV,           1, 32'h0,        0};
    vecs[4]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd10, 5'd0,  RV,           1, 32'h0,        0};
    vecs[5]  = '{1, 5'd10, 32'h00000055, 0, 5'd0,  5'd10, 5'd0,  32'h55,       0, 32'h0,        0};
    vecs[6]  = '{1, 5'd3,  32'h00000077, 1, 5'd3,  5'd3,  5'd10, 32'h77,       1, 32'h55,       0};
    vecs[7]  = '{0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  5'd3,  32'h0,        0, 32'h77,       1};
    vecs[8]  = '{1, 5'd20, 32'h00000001, 0, 5'd0,  5'd20, 5'd3,  32'h1,        0, 32'h77,       1};
    vecs[9]  = '{0, 5'd0,  32'h0,        1, 5'd3,  5'd3,  5'd20, 32'h77,       1, 32'h1,        0};
    vecs[10] = '{1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 5'd31, 5'd1,  32'hFFFFFFFF, 1, RV,           0};

    rst = 1'b1; rd_wen = 0; rd_idx = 0; rd_wdata = 0; rsv_en = 0; rsv_idx = 0;
    rs1_idx = 5'd0; rs2_idx = 5'd7;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("reset_x0_data", rs1_rdata, 32'h0);
    check("reset_x7_data", rs2_rdata, RV);
    check("reset_busy1", 32'(rs1_busy), 32'h0);
    check("reset_busy2", 32'(rs2_busy), 32'h0);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rd_wen = vecs[i].wen; rd_idx = vecs[i].rd; rd_wdata = vecs[i].wdata;
      rsv_en = vecs[i].rsv; rsv_idx = vecs[i].rsvi;
      rs1_idx = vecs[i].r1; rs2_idx = vecs[i].r2;
      @(posedge clk); #1;
      rd_wen = 0; rsv_en = 0;
      #1;
      check($sformatf("vec%0d_rs1_data", i), rs1_rdata, vecs[i].e1);
      check($sformatf("vec%0d_rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].eb1));
      check($sformatf("vec%0d_rs2_data", i), rs2_rdata, vecs[i].e2);
      check($sformatf("vec%0d_rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].eb2));
    end

    // Same-cycle write and read of x9
    @(negedge clk);
    rs2_idx = 5'd9; rd_wen = 1; rd_idx = 5'd9; rd_wdata = 32'h42;
    #1;
`ifdef LETC_REG_FILE_BYPASS_EN
    check("x9_same_cycle", rs2_rdata, 32'h42);
`else
    check("x9_same_cycle", rs2_rdata, RV);
`endif
    @(posedge clk); #1;
    rd_wen = 0; #1;
    check("x9_next_cycle", rs2_rdata, 32'h42);

    // Reserve x4, write x4 while reserving x6, then async reset mid-cycle
    @(negedge clk);
    rsv_en = 1; rsv_idx = 5'd4;
    @(posedge clk); #1;
    rsv_en = 1; rsv_idx = 5'd6; rd_wen = 1; rd_idx = 5'd4; rd_wdata = 32'hFF;
    @(posedge clk); #1;
    rsv_en = 0; rd_wen = 0; rs1_idx = 5'd4; rs2_idx = 5'd6;
    #1;
    check("x4_before_rst", rs1_rdata, 32'hFF);
    check("x6_busy_before_rst", 32'(rs2_busy), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("x4_async_rst", rs1_rdata, RV);
    check("x6_busy_async_rst", 32'(rs2_busy), 32'h0);
    // A write presented while rst is high must not land
    rd_wen = 1; rd_idx = 5'd4; rd_wdata = 32'h1111;
    rsv_en = 1; rsv_idx = 5'd6;
    @(posedge clk); #1;
    check("x4_write_in_rst", rs1_rdata, RV);
    check("x6_rsv_in_rst", 32'(rs2_busy), 32'h0);
    rd_wen = 0; rsv_en = 0;
    @(negedge clk) rst = 1'b0;

    // Randomized run against the reference model
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = (r == 0) ? 32'h0 : RV;
      m_busy[r] = 1'b0;
    end
    @(posedge clk); #1;
    for (int c = 0; c < 300; c++) begin
      logic [31:0] e1, e2;
      logic        b1, b2;
      rd_wen   = 1'($urandom_range(0, 1));
      rd_idx   = 5'($urandom_range(0, 7));
      rd_wdata = $urandom;
      rsv_en   = ($urandom_range(0, 3) == 0);
      rsv_idx  = 5'($urandom_range(0, 7));
      rs1_idx  = 5'($urandom_range(0, 7));
      rs2_idx  = (c % 16 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      #1;
      e1 = m_regs[rs1_idx]; b1 = m_busy[rs1_idx];
      e2 = m_regs[rs2_idx]; b2 = m_busy[rs2_idx];
`ifdef LETC_REG_FILE_BYPASS_EN
      if (rd_wen && rd_idx != 0 && rd_idx == rs1_idx) begin
        e1 = rd_wdata; b1 = rsv_en && rsv_idx == rs1_idx;
      end
      if (rd_wen && rd_idx != 0 && rd_idx == rs2_idx) begin
        e2 = rd_wdata; b2 = rsv_en && rsv_idx == rs2_idx;
      end
`endif
      check($sformatf("rnd%0d_rs1_data", c), rs1_rdata, e1);
      check($sformatf("rnd%0d_rs1_busy", c), 32'(rs1_busy), 32'(b1));
      check($sformatf("rnd%0d_rs2_data", c), rs2_rdata, e2);
      check($sformatf("rnd%0d_rs2_busy", c), 32'(rs2_busy), 32'(b2));
      @(posedge clk);
      if (rd_wen && rd_idx != 0) begin
        m_regs[rd_idx] = rd_wdata;
        m_busy[rd_idx] = 1'b0;
      end
      if (rsv_en && rsv_idx != 0) m_busy[rsv_idx] = 1'b1;
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
